// File: rtl/mem_shim.sv
// ---------------------------------------------------------------------------
// mem_shim
//   Bridges the MPEG2 decoder's memory request/response FIFOs to a
//   single-port Avalon-MM style DDR3 master. One command is popped at a time
//   and issued as a single-beat DDR3 read or write. Read data returned by
//   DDR3 is pushed into the response FIFO one cycle later.
//
//   Optional feature macro: MEM_SHIM_BSWAP_EN
//     defined   : write data and read data are byte-reversed (byte 0 <-> 7)
//     undefined : data passes through unmodified (default)
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   mem_req_rd_cmd/addr/dta  request FIFO head: command, word address, data
//   mem_req_rd_valid         request FIFO not empty
//   mem_req_rd_en            request FIFO pop strobe (combinational)
//   mem_res_wr_dta/en        response FIFO push data/strobe
//   mem_res_wr_almost_full   response FIFO almost full (blocks pops)
//   ddr3_*                   Avalon-MM master toward DDR3
// ---------------------------------------------------------------------------
module mem_shim #(
    parameter logic [3:0] ADDR_BASE = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_req_rd_cmd,
    input  logic [21:0] mem_req_rd_addr,
    input  logic [63:0] mem_req_rd_dta,
    output logic        mem_req_rd_en,
    input  logic        mem_req_rd_valid,
    output logic [63:0] mem_res_wr_dta,
    output logic        mem_res_wr_en,
    input  logic        mem_res_wr_almost_full,
    output logic [28:0] ddr3_addr,
    output logic [7:0]  ddr3_burstcnt,
    output logic        ddr3_read,
    output logic        ddr3_write,
    output logic [63:0] ddr3_writedata,
    output logic [7:0]  ddr3_byteenable,
    input  logic [63:0] ddr3_readdata,
    input  logic        ddr3_readdatavalid,
    input  logic        ddr3_waitrequest
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    state_t      state_q, state_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [28:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        res_en_q, res_en_d;
    logic [63:0] res_dta_q, res_dta_d;
    // Set by reset: drops read data belonging to reads issued before reset.
    logic        rd_ignore_q, rd_ignore_d;

    logic        slot_free;
    logic        pop;
    logic        res_take;
    logic [63:0] req_data_in;
    logic [63:0] rsp_data_in;

`ifdef MEM_SHIM_BSWAP_EN
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bswap
            assign req_data_in[gi*8 +: 8] = mem_req_rd_dta[(7-gi)*8 +: 8];
            assign rsp_data_in[gi*8 +: 8] = ddr3_readdata[(7-gi)*8 +: 8];
        end
    endgenerate
`else
    assign req_data_in = mem_req_rd_dta;
    assign rsp_data_in = ddr3_readdata;
`endif

    // A new command may be loaded when idle, or in the very cycle DDR3
    // accepts the current one (back-to-back issue).
    assign slot_free     = (state_q == IDLE) || !ddr3_waitrequest;
    assign pop           = slot_free && mem_req_rd_valid && !mem_res_wr_almost_full;
    // Never pop while reset holds the flops: the command would be lost.
    assign mem_req_rd_en = pop && !rst;

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_ignore_d = rd_ignore_q;

        if (pop) begin
            case (mem_req_rd_cmd)
                CMD_READ, CMD_WRITE: begin
                    read_d  = (mem_req_rd_cmd == CMD_READ);
                    write_d = (mem_req_rd_cmd == CMD_WRITE);
                    addr_d  = {ADDR_BASE, mem_req_rd_addr, 3'b000};
                    wdata_d = req_data_in;
                    state_d = ISSUE;
                    if (mem_req_rd_cmd == CMD_READ) begin
                        rd_ignore_d = 1'b0;
                    end
                end
                default: begin
                    // NOOP / REFRESH: consumed, no DDR3 traffic.
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end else if (state_q == ISSUE && !ddr3_waitrequest) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            state_d = IDLE;
        end
    end

    // Response path runs independently of the command FSM.
    assign res_take  = ddr3_readdatavalid && !rd_ignore_q;
    assign res_en_d  = res_take;
    assign res_dta_d = res_take ? rsp_data_in : res_dta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            res_en_q    <= 1'b0;
            res_dta_q   <= '0;
            rd_ignore_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            res_en_q    <= res_en_d;
            res_dta_q   <= res_dta_d;
            rd_ignore_q <= rd_ignore_d;
        end
    end

    assign ddr3_read       = read_q;
    assign ddr3_write      = write_q;
    assign ddr3_addr       = addr_q;
    assign ddr3_writedata  = wdata_q;
    assign ddr3_burstcnt   = 8'd1;
    assign ddr3_byteenable = 8'hFF;
    assign mem_res_wr_en   = res_en_q;
    assign mem_res_wr_dta  = res_dta_q;

endmodule

// File: tb/tb_mem_shim.sv
// ---------------------------------------------------------------------------
// tb_mem_shim
//   Table-driven directed bench for mem_shim plus hand-written sequences for
//   reset during ISSUE and stale read data after reset.
// ---------------------------------------------------------------------------
module tb_mem_shim;

    logic        clk;
    logic        rst;
    logic [1:0]  mem_req_rd_cmd;
    logic [21:0] mem_req_rd_addr;
    logic [63:0] mem_req_rd_dta;
    logic        mem_req_rd_en;
    logic        mem_req_rd_valid;
    logic [63:0] mem_res_wr_dta;
    logic        mem_res_wr_en;
    logic        mem_res_wr_almost_full;
    logic [28:0] ddr3_addr;
    logic [7:0]  ddr3_burstcnt;
    logic        ddr3_read;
    logic        ddr3_write;
    logic [63:0] ddr3_writedata;
    logic [7:0]  ddr3_byteenable;
    logic [63:0] ddr3_readdata;
    logic        ddr3_readdatavalid;
    logic        ddr3_waitrequest;

    mem_shim dut (
        .clk                    (clk),
        .rst                    (rst),
        .mem_req_rd_cmd         (mem_req_rd_cmd),
        .mem_req_rd_addr        (mem_req_rd_addr),
        .mem_req_rd_dta         (mem_req_rd_dta),
        .mem_req_rd_en          (mem_req_rd_en),
        .mem_req_rd_valid       (mem_req_rd_valid),
        .mem_res_wr_dta         (mem_res_wr_dta),
        .mem_res_wr_en          (mem_res_wr_en),
        .mem_res_wr_almost_full (mem_res_wr_almost_full),
        .ddr3_addr              (ddr3_addr),
        .ddr3_burstcnt          (ddr3_burstcnt),
        .ddr3_read              (ddr3_read),
        .ddr3_write             (ddr3_write),
        .ddr3_writedata         (ddr3_writedata),
        .ddr3_byteenable        (ddr3_byteenable),
        .ddr3_readdata          (ddr3_readdata),
        .ddr3_readdatavalid     (ddr3_readdatavalid),
        .ddr3_waitrequest       (ddr3_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [21:0] addr;
        logic [63:0] dta;
        logic        valid;
        logic        af;
        logic        wt;
        logic        rdv;
        logic [63:0] rdata;
        logic        e_en;      // pop strobe before the edge
        logic        e_rd;      // values after the edge
        logic        e_wr;
        logic [28:0] e_addr;
        logic [63:0] e_wdata;
        logic        e_res_en;
        logic [63:0] e_res_dta;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [63:0] bsw(input logic [63:0] x);
`ifdef MEM_SHIM_BSWAP_EN
        logic [63:0] y;
        for (int b = 0; b < 8; b++) y[b*8 +: 8] = x[(7-b)*8 +: 8];
        return y;
`else
        return x;
`endif
    endfunction

    function automatic void add(
        input logic [1:0] cmd, input logic [21:0] addr, input logic [63:0] dta,
        input logic valid, input logic af, input logic wt, input logic rdv,
        input logic [63:0] rdata, input logic e_en, input logic e_rd,
        input logic e_wr, input logic [28:0] e_addr, input logic [63:0] e_wdata,
        input logic e_res_en, input logic [63:0] e_res_dta);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.dta = dta; v.valid = valid; v.af = af;
        v.wt = wt; v.rdv = rdv; v.rdata = rdata; v.e_en = e_en; v.e_rd = e_rd;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_res_en = e_res_en; v.e_res_dta = e_res_dta;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [21:0] addr,
                         input logic [63:0] dta, input logic valid, input logic af,
                         input logic wt, input logic rdv, input logic [63:0] rdata);
        mem_req_rd_cmd         = cmd;
        mem_req_rd_addr        = addr;
        mem_req_rd_dta         = dta;
        mem_req_rd_valid       = valid;
        mem_res_wr_almost_full = af;
        ddr3_waitrequest       = wt;
        ddr3_readdatavalid     = rdv;
        ddr3_readdata          = rdata;
    endtask

    localparam logic [63:0] D_WR  = 64'hDEADBEEFCAFEBABE;
    localparam logic [63:0] D_RSP = 64'h0123456789ABCDEF;
    localparam logic [63:0] D_RS2 = 64'hFEDCBA9876543210;

    initial begin
        // cmd addr dta valid af wt rdv rdata | en rd wr addr wdata res_en res_dta
        add(2'd0, 22'h0, 64'h0, 0,0,0, 0,64'h0,   0, 0,0, 29'h0, 64'h0, 0, 64'h0);
        add(2'd3, 22'h123456, D_WR, 1,0,0, 0,64'h0,
            1, 0,1, {4'b0011,22'h123456,3'b000}, D_WR, 0, 64'h0);
        add(2'd2, 22'h1BCDEF, 64'h1111, 1,0,0, 0,64'h0,
            1, 1,0, {4'b0011,22'h1BCDEF,3'b000}, 64'h1111, 0, 64'h0);
        add(2'd0, 22'h0, 64'h0, 0,0,0, 0,64'h0,
            0, 0,0, {4'b0011,22'h1BCDEF,3'b000}, 64'h1111, 0, 64'h0);
        add(2'd0, 22'h0, 64'h0, 0,0,0, 1,D_RSP,
            0, 0,0, {4'b0011,22'h1BCDEF,3'b000}, 64'h1111, 1, D_RSP);
        add(2'd0, 22'h0, 64'h0, 0,0,0, 0,64'h0,
            0, 0,0, {4'b0011,22'h1BCDEF,3'b000}, 64'h1111, 0, D_RSP);
        add(2'd2, 22'h000001, 64'h2222, 1,0,1, 0,64'h0,
            1, 1,0, {4'b0011,22'h000001,3'b000}, 64'h2222, 0, D_RSP);
        add(2'd3, 22'h3FFFFF, 64'h3333, 1,0,1, 0,64'h0,
            0, 1,0, {4'b0011,22'h000001,3'b000}, 64'h2222, 0, D_RSP);
        add(2'd3, 22'h3FFFFF, 64'h3333, 1,0,1, 0,64'h0,
            0, 1,0, {4'b0011,22'h000001,3'b000}, 64'h2222, 0, D_RSP);
        add(2'd3, 22'h3FFFFF, 64'h3333, 1,0,0, 0,64'h0,
            1, 0,1, {4'b0011,22'h3FFFFF,3'b000}, 64'h3333, 0, D_RSP);
        add(2'd0, 22'h0, 64'h0, 1,0,0, 0,64'h0,
            1, 0,0, {4'b0011,22'h3FFFFF,3'b000}, 64'h3333, 0, D_RSP);
        add(2'd1, 22'h0, 64'h0, 1,0,0, 0,64'h0,
            1, 0,0, {4'b0011,22'h3FFFFF,3'b000}, 64'h3333, 0, D_RSP);
        add(2'd2, 22'h0, 64'h0, 1,1,0, 0,64'h0,
            0, 0,0, {4'b0011,22'h3FFFFF,3'b000}, 64'h3333, 0, D_RSP);
        add(2'd0, 22'h0, 64'h0, 0,1,0, 1,D_RS2,
            0, 0,0, {4'b0011,22'h3FFFFF,3'b000}, 64'h3333, 1, D_RS2);
        add(2'd2, 22'h2AAAAA, 64'h4444, 1,0,0, 0,64'h0,
            1, 1,0, {4'b0011,22'h2AAAAA,3'b000}, 64'h4444, 0, D_RS2);

        rst = 1'b1;
        drive(2'd0, 22'h0, 64'h0, 0, 0, 0, 0, 64'h0);
        repeat (2) @(negedge clk);
        n_vec++;
        chk("rst_read",  {63'h0, ddr3_read}, 64'h0);
        chk("rst_write", {63'h0, ddr3_write}, 64'h0);
        chk("rst_addr",  {35'h0, ddr3_addr}, 64'h0);
        chk("rst_wdata", ddr3_writedata, 64'h0);
        chk("rst_res_en", {63'h0, mem_res_wr_en}, 64'h0);
        chk("rst_res_dta", mem_res_wr_dta, 64'h0);
        chk("rst_burstcnt", {56'h0, ddr3_burstcnt}, 64'h1);
        chk("rst_byteen", {56'h0, ddr3_byteenable}, 64'hFF);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].cmd, vq[i].addr, vq[i].dta, vq[i].valid, vq[i].af,
                  vq[i].wt, vq[i].rdv, vq[i].rdata);
            #1;
            n_vec++;
            chk($sformatf("v%0d_rd_en", i), {63'h0, mem_req_rd_en}, {63'h0, vq[i].e_en});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_read", i),  {63'h0, ddr3_read},  {63'h0, vq[i].e_rd});
            chk($sformatf("v%0d_write", i), {63'h0, ddr3_write}, {63'h0, vq[i].e_wr});
            chk($sformatf("v%0d_addr", i),  {35'h0, ddr3_addr},  {35'h0, vq[i].e_addr});
            chk($sformatf("v%0d_wdata", i), ddr3_writedata, bsw(vq[i].e_wdata));
            chk($sformatf("v%0d_res_en", i), {63'h0, mem_res_wr_en}, {63'h0, vq[i].e_res_en});
            chk($sformatf("v%0d_res_dta", i), mem_res_wr_dta, bsw(vq[i].e_res_dta));
            $display("vector %0d: cmd=%0d valid=%0b wait=%0b rd_en=%0b read=%0b write=%0b addr=%h res_en=%0b",
                     i, vq[i].cmd, vq[i].valid, vq[i].wt, vq[i].e_en, ddr3_read,
                     ddr3_write, ddr3_addr, mem_res_wr_en);
        end

        // Reset while a read is pending in ISSUE (stalled): drops immediately.
        @(negedge clk);
        drive(2'd0, 22'h0, 64'h0, 0, 0, 1, 0, 64'h0);
        #1;
        n_vec++;
        chk("pre_rst_read", {63'h0, ddr3_read}, 64'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_read",  {63'h0, ddr3_read}, 64'h0);
        chk("async_rst_write", {63'h0, ddr3_write}, 64'h0);
        chk("async_rst_addr",  {35'h0, ddr3_addr}, 64'h0);
        $display("reset in ISSUE: read=%0b write=%0b", ddr3_read, ddr3_write);

        // After reset the FSM is IDLE: a pop happens even with waitrequest=1.
        @(negedge clk);
        rst = 1'b0;
        drive(2'd0, 22'h0, 64'h0, 1, 0, 1, 0, 64'h0);
        #1;
        n_vec++;
        chk("post_rst_idle_pop", {63'h0, mem_req_rd_en}, 64'h1);
        @(posedge clk);
        #1;
        $display("post reset pop: rd_en sampled, read=%0b", ddr3_read);

        // Stale read data from before reset is ignored.
        @(negedge clk);
        drive(2'd0, 22'h0, 64'h0, 0, 0, 0, 1, 64'hAAAA5555AAAA5555);
        @(posedge clk);
        #1;
        n_vec++;
        chk("stale_res_en", {63'h0, mem_res_wr_en}, 64'h0);
        $display("stale read data: res_en=%0b", mem_res_wr_en);

        // A new read re-enables the response path.
        @(negedge clk);
        drive(2'd2, 22'h000010, 64'h0, 1, 0, 0, 0, 64'h0);
        #1;
        n_vec++;
        chk("new_rd_pop", {63'h0, mem_req_rd_en}, 64'h1);
        @(posedge clk);
        #1;
        chk("new_rd_read", {63'h0, ddr3_read}, 64'h1);
        chk("new_rd_addr", {35'h0, ddr3_addr}, {35'h0, 4'b0011, 22'h000010, 3'b000});
        @(negedge clk);
        drive(2'd0, 22'h0, 64'h0, 0, 0, 0, 1, 64'h5A5A5A5A12345678);
        @(posedge clk);
        #1;
        n_vec++;
        chk("new_rd_res_en",  {63'h0, mem_res_wr_en}, 64'h1);
        chk("new_rd_res_dta", mem_res_wr_dta, bsw(64'h5A5A5A5A12345678));
        chk("new_rd_idle",    {63'h0, ddr3_read}, 64'h0);
        $display("new read response: res_en=%0b dta=%h", mem_res_wr_en, mem_res_wr_dta);
        @(negedge clk);
        drive(2'd0, 22'h0, 64'h0, 0, 0, 0, 0, 64'h0);
        @(posedge clk);
        #1;
        n_vec++;
        chk("res_en_one_cycle", {63'h0, mem_res_wr_en}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_shim.md
Name:
mem_shim

Overview:
- Bridges the MPEG2 decoder's memory request FIFO and memory response FIFO to a single-port Avalon-MM style DDR3 master.
- Pops one command at a time from the request FIFO and issues single-beat DDR3 reads and writes.
- Returns read data to the response FIFO.
- Sits between the decoder core's memory FIFOs and the DDR3 port of the framework.

Parameters:
- ADDR_BASE, 4'b0011: fixed upper 4 bits of every DDR3 address. Places the decoder window in DDR3.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_req_rd_cmd  in  2  command code: 0 NOOP, 1 REFRESH, 2 READ, 3 WRITE.
- mem_req_rd_addr  in  22  64-bit word address.
- mem_req_rd_dta  in  64  write data.
- mem_req_rd_en  out  1  request FIFO pop strobe.
- mem_req_rd_valid  in  1  request FIFO not empty.
- mem_res_wr_dta  out  64  read data to response FIFO.
- mem_res_wr_en  out  1  response FIFO push strobe.
- mem_res_wr_almost_full  in  1  response FIFO almost full.
- ddr3_addr  out  29  DDR3 address.
- ddr3_burstcnt  out  8  burst count, constant 1.
- ddr3_read  out  1  read request.
- ddr3_write  out  1  write request.
- ddr3_writedata  out  64  write data.
- ddr3_byteenable  out  8  constant 8'hFF.
- ddr3_readdata  in  64  read data.
- ddr3_readdatavalid  in  1  read data strobe.
- ddr3_waitrequest  in  1  DDR3 stall.

Behaviour:
- Single clock. Reset is asynchronous, active-high.
- Reset values:
  - ddr3_read = 0, ddr3_write = 0.
  - ddr3_addr = 0, ddr3_writedata = 0.
  - ddr3_burstcnt = 1, ddr3_byteenable = 8'hFF.
  - mem_res_wr_en = 0, mem_res_wr_dta = 0.
  - FSM in IDLE.
- Reset asserted mid-operation drops any pending DDR3 command immediately. Read data still outstanding after reset is ignored until the first new read is issued.
- Two-state FSM.
- IDLE state:
  - ddr3_read and ddr3_write are 0.
  - Pop condition (combinational): mem_req_rd_en = mem_req_rd_valid & ~mem_res_wr_almost_full.
- Behaviour on a popping clock edge, by command:
  - READ or WRITE: latch ddr3_addr = {ADDR_BASE, mem_req_rd_addr, 3'b000} and ddr3_writedata = mem_req_rd_dta. Assert ddr3_read (cmd 2) or ddr3_write (cmd 3). Go to ISSUE.
  - NOOP or REFRESH: consumed and discarded. Stay in IDLE; no DDR3 activity.
- ISSUE state:
  - ddr3_read/ddr3_write, address and data are held stable while ddr3_waitrequest = 1.
  - mem_req_rd_en = 0 while ddr3_waitrequest = 1.
  - In the cycle ddr3_waitrequest = 0 the command is accepted by DDR3.
  - In that cycle mem_req_rd_en = mem_req_rd_valid & ~mem_res_wr_almost_full (combinational, back-to-back pop).
  - If a pop occurs: load the next command exactly as in IDLE. NOOP/REFRESH → IDLE with read/write deasserted.
  - If no pop: deassert read/write, go to IDLE.
- Throughput: one DDR3 command per cycle when waitrequest stays low and requests are continuously available. Latency from pop to ddr3_read/write asserted is 1 cycle.
- Response path: on each clock with ddr3_readdatavalid = 1, register mem_res_wr_dta = ddr3_readdata and set mem_res_wr_en = 1 for exactly one cycle. Otherwise mem_res_wr_en = 0.
- Response latency is 1 cycle from readdatavalid. This path is independent of the FSM state.
- Reads are not counted. Backpressure relies on the almost_full margin of the response FIFO. The margin must be at least 2 entries.
- Write data and address bit widths: 4 + 22 + 3 = 29, with no truncation.

Optional Feature:
- Macro: MEM_SHIM_BSWAP_EN.
- Defined: ddr3_writedata is the byte-reversed mem_req_rd_dta (byte 0 ↔ byte 7, etc.). mem_res_wr_dta is the byte-reversed ddr3_readdata. Timing is unchanged.
- Undefined (default): data passes through unmodified.

Test Plan:
- Write, waitrequest=0:
  - Stimulus: cmd=3, addr=22'h123456, dta=64'hDEADBEEFCAFEBABE, valid=1.
  - Response: one edge after the pop, ddr3_write=1, ddr3_addr={4'b0011,22'h123456,3'b000}, ddr3_writedata=64'hDEADBEEFCAFEBABE, ddr3_read=0.
- Read, waitrequest=0:
  - Stimulus: cmd=2, addr=22'h1BCDEF.
  - Response: ddr3_read=1, ddr3_addr={4'b0011,22'h1BCDEF,3'b000}. Next cycle returns to IDLE with read=0.
- Read response:
  - Stimulus: ddr3_readdatavalid=1 for one cycle with readdata=64'h0123456789ABCDEF.
  - Response: the following cycle mem_res_wr_en=1, mem_res_wr_dta=64'h0123456789ABCDEF, then en=0.
- Waitrequest stall:
  - Stimulus: waitrequest=1, READ pending.
  - Response: ddr3_read stays 1 and mem_req_rd_en=0 for every stalled cycle.
  - Stimulus: drop waitrequest while valid=1.
  - Response: mem_req_rd_en=1 in that same cycle.
- NOOP/REFRESH:
  - Stimulus: cmd=0, then cmd=1, with valid=1.
  - Response: each is popped in one cycle and ddr3_read/ddr3_write never assert.
- Almost-full gating and reset:
  - Stimulus: mem_res_wr_almost_full=1 with valid=1.
  - Response: mem_req_rd_en=0.
  - Stimulus: assert rst during ISSUE.
  - Response: read/write drop to 0 immediately and the FSM is in IDLE.
